// File: rtl/writeback.sv
// writeback: final stage of the MIPS pipeline.
//
// Takes the instruction retiring from mem_stage, selects the register-file
// destination, builds the write-back value (load extraction/extension, JAL/JALR
// link) and registers everything for one cycle toward decode.
//
// Ports:
//   clock, reset_n      pipeline clock, asynchronous active-low reset
//   valid_in, stall     capture qualifier; stall wins and forces a bubble
//   insn_in, pc_in      retiring instruction word and its PC (bit 0 = MSB)
//   alu_result_in       ALU result, or the effective address for loads
//   mem_data_in         word read at the word-aligned load address
//   wb_data, wb_rd      registered write-back value and destination register
//   wb_we               registered one-cycle register-file write strobe
//   misaligned          one-cycle pulse for a misaligned LH/LHU/LW
//   retired_count       number of captured valid instructions (wraps)
module writeback #(
   parameter int unsigned RESET_PC_LINK = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        valid_in,
   input  logic        stall,
   input  logic [0:31] insn_in,
   input  logic [0:31] pc_in,
   input  logic [0:31] alu_result_in,
   input  logic [0:31] mem_data_in,
   output logic [0:31] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_we,
   output logic        misaligned,
   output logic [0:31] retired_count
);

   logic [5:0]  opcode;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [1:0]  addr_lo;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] link;

   logic [31:0] data_c;
   logic [4:0]  dest_c;
   logic        we_c;
   logic        mis_c;
   logic        capture;

   logic [31:0] data_q, data_d;
   logic [4:0]  rd_q, rd_d;
   logic        we_q, we_d;
   logic        mis_q, mis_d;
   logic [31:0] count_q, count_d;

   // Instruction fields use big-endian bit numbering: bit 0 is the MSB.
   assign opcode  = insn_in[0:5];
   assign rt      = insn_in[11:15];
   assign rd      = insn_in[16:20];
   assign funct   = insn_in[26:31];
   assign addr_lo = alu_result_in[30:31];
   assign link    = pc_in + 32'(RESET_PC_LINK);
   assign capture = valid_in && !stall;

   // Big-endian lane select: byte/halfword 0 sits in the most significant bits.
   always_comb begin
      byte_sel = mem_data_in[0:7];
      unique case (addr_lo)
         2'd0: byte_sel = mem_data_in[0:7];
         2'd1: byte_sel = mem_data_in[8:15];
         2'd2: byte_sel = mem_data_in[16:23];
         2'd3: byte_sel = mem_data_in[24:31];
         default: byte_sel = mem_data_in[0:7];
      endcase
      half_sel = addr_lo[1] ? mem_data_in[16:31] : mem_data_in[0:15];
   end

   // Destination, value and write/misalignment decode.
   always_comb begin
      dest_c = rt;
      data_c = alu_result_in;
      we_c   = 1'b0;
      mis_c  = 1'b0;
      case (opcode)
         6'h00: begin
            dest_c = rd;
            we_c   = 1'b1;
            case (funct)
               6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: we_c = 1'b0;
               6'h09: data_c = link;
               default: ;
            endcase
            if (insn_in == 32'h0) we_c = 1'b0;
         end
         6'h03: begin
            dest_c = 5'd31;
            data_c = link;
            we_c   = 1'b1;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: we_c = 1'b1;
         6'h20: begin
            data_c = {{24{byte_sel[7]}}, byte_sel};
            we_c   = 1'b1;
         end
         6'h24: begin
            data_c = {24'h0, byte_sel};
            we_c   = 1'b1;
         end
         6'h21: begin
            data_c = {{16{half_sel[15]}}, half_sel};
            we_c   = 1'b1;
            mis_c  = addr_lo[0];
         end
         6'h25: begin
            data_c = {16'h0, half_sel};
            we_c   = 1'b1;
            mis_c  = addr_lo[0];
         end
         6'h23: begin
            data_c = mem_data_in;
            we_c   = 1'b1;
            mis_c  = (addr_lo != 2'd0);
         end
         default: we_c = 1'b0;
      endcase
      // Misaligned loads and writes to $zero keep their rd/data but never strobe.
      if (mis_c || dest_c == 5'd0) we_c = 1'b0;
   end

   // Bubbles hold rd/data/count and clear the strobes.
   always_comb begin
      data_d  = data_q;
      rd_d    = rd_q;
      we_d    = 1'b0;
      mis_d   = 1'b0;
      count_d = count_q;
      if (capture) begin
         data_d  = data_c;
         rd_d    = dest_c;
         we_d    = we_c;
         mis_d   = mis_c;
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= 32'h0;
         rd_q    <= 5'd0;
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         count_q <= 32'h0;
      end else begin
         data_q  <= data_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         mis_q   <= mis_d;
         count_q <= count_d;
      end
   end

   assign wb_data       = data_q;
   assign wb_rd         = rd_q;
   assign wb_we         = we_q;
   assign misaligned    = mis_q;
   assign retired_count = count_q;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: the stimulus process pushes one expected
// entry per driven cycle; the monitor pops and compares one cycle later.
module tb_writeback;

   logic        clock;
   logic        reset_n;
   logic        valid_in;
   logic        stall;
   logic [31:0] insn_in;
   logic [31:0] pc_in;
   logic [31:0] alu_result_in;
   logic [31:0] mem_data_in;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic        misaligned;
   logic [31:0] retired_count;

   writeback #(.RESET_PC_LINK(8)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .valid_in      (valid_in),
      .stall         (stall),
      .insn_in       (insn_in),
      .pc_in         (pc_in),
      .alu_result_in (alu_result_in),
      .mem_data_in   (mem_data_in),
      .wb_data       (wb_data),
      .wb_rd         (wb_rd),
      .wb_we         (wb_we),
      .misaligned    (misaligned),
      .retired_count (retired_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic        mis;
      logic        chk;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] cnt;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] exp_cnt = 32'h0;
   logic [4:0]  last_rd = 5'd0;
   logic [31:0] last_data = 32'h0;
   logic        last_known = 1'b1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // Drive one cycle of inputs at the falling edge and queue its expected result.
   task automatic drive(input logic v, input logic s, input logic [31:0] insn,
                        input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] mem, input logic we, input logic mis,
                        input logic chk, input logic [4:0] rd,
                        input logic [31:0] data, input string name);
      exp_t e;
      @(negedge clock);
      valid_in      = v;
      stall         = s;
      insn_in       = insn;
      pc_in         = pc;
      alu_result_in = alu;
      mem_data_in   = mem;
      e.name = name;
      if (v && !s) begin
         exp_cnt    = exp_cnt + 32'd1;
         e.we       = we;
         e.mis      = mis;
         e.chk      = chk;
         e.rd       = rd;
         e.data     = data;
         last_known = chk;
         last_rd    = rd;
         last_data  = data;
      end else begin
         e.we   = 1'b0;
         e.mis  = 1'b0;
         e.chk  = last_known;
         e.rd   = last_rd;
         e.data = last_data;
      end
      e.cnt = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, "idle");
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
      #2;
      check("scoreboard_drain", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: compare every driven cycle one clock after it was issued.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, ".we"}, 32'(wb_we), 32'(e.we));
            check({e.name, ".misaligned"}, 32'(misaligned), 32'(e.mis));
            check({e.name, ".count"}, retired_count, e.cnt);
            if (e.chk) begin
               check({e.name, ".rd"}, 32'(wb_rd), 32'(e.rd));
               check({e.name, ".data"}, wb_data, e.data);
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      valid_in = 1'b0;
      stall = 1'b0;
      insn_in = 32'h0;
      pc_in = 32'h0;
      alu_result_in = 32'h0;
      mem_data_in = 32'h0;
      #12;
      check("reset.data", wb_data, 32'h0);
      check("reset.rd", 32'(wb_rd), 32'h0);
      check("reset.we", 32'(wb_we), 32'h0);
      check("reset.misaligned", 32'(misaligned), 32'h0);
      check("reset.count", retired_count, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;

      //   v     s     insn          pc            alu           mem           we    mis   chk   rd     data
      drive(1'b1, 1'b0, 32'h00221821, 32'h80020000, 32'h00000007, 32'h0,        1'b1, 1'b0, 1'b1, 5'd3,  32'h00000007, "addu");
      drive(1'b1, 1'b0, 32'h80850001, 32'h80020004, 32'h80020001, 32'h12803456, 1'b1, 1'b0, 1'b1, 5'd5,  32'hFFFFFF80, "lb");
      drive(1'b1, 1'b0, 32'h90850001, 32'h80020008, 32'h80020001, 32'h12803456, 1'b1, 1'b0, 1'b1, 5'd5,  32'h00000080, "lbu");
      drive(1'b1, 1'b0, 32'h80850003, 32'h8002000C, 32'h80020003, 32'h12345678, 1'b1, 1'b0, 1'b1, 5'd5,  32'h00000078, "lb_pos");
      drive(1'b1, 1'b0, 32'h84860002, 32'h80020010, 32'h80020002, 32'h1234ABCD, 1'b1, 1'b0, 1'b1, 5'd6,  32'hFFFFABCD, "lh");
      drive(1'b1, 1'b0, 32'h94860000, 32'h80020014, 32'h80020000, 32'h8234ABCD, 1'b1, 1'b0, 1'b1, 5'd6,  32'h00008234, "lhu");
      drive(1'b1, 1'b0, 32'h8C870002, 32'h80020018, 32'h80020002, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, 5'd7,  32'h1234ABCD, "lw_misaligned");
      drive(1'b1, 1'b0, 32'h84860001, 32'h8002001C, 32'h80020001, 32'h1234ABCD, 1'b0, 1'b1, 1'b0, 5'd6,  32'h0,        "lh_misaligned");
      drive(1'b1, 1'b0, 32'h8C870000, 32'h80020020, 32'h80020000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd7,  32'hDEADBEEF, "lw");
      drive(1'b1, 1'b0, 32'h0C000100, 32'h80020010, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'h80020018, "jal");
      drive(1'b1, 1'b0, 32'h0100F809, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'h00000004, "jalr_wrap");
      drive(1'b1, 1'b0, 32'hAC850000, 32'h80020028, 32'h80020000, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        "sw");
      drive(1'b1, 1'b0, 32'h10220003, 32'h8002002C, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        "beq");
      drive(1'b1, 1'b0, 32'h00000000, 32'h80020030, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        "nop");
      drive(1'b1, 1'b0, 32'h20200005, 32'h80020034, 32'h00000006, 32'h0,        1'b0, 1'b0, 1'b1, 5'd0,  32'h00000006, "addi_r0");
      drive(1'b1, 1'b0, 32'h03E00008, 32'h80020038, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        "jr");
      drive(1'b1, 1'b0, 32'h00430018, 32'h8002003C, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        "mult");
      drive(1'b1, 1'b0, 32'h24090010, 32'h80020040, 32'h00000010, 32'h0,        1'b1, 1'b0, 1'b1, 5'd9,  32'h00000010, "addiu");
      drive(1'b1, 1'b0, 32'h3C0A1234, 32'h80020044, 32'h12340000, 32'h0,        1'b1, 1'b0, 1'b1, 5'd10, 32'h12340000, "lui");
      drive(1'b0, 1'b0, 32'h00221821, 32'h0,        32'h00000099, 32'h0,        1'b0, 1'b0, 1'b1, 5'd3,  32'h00000099, "not_valid");

      // Alternate stall with valid held high: only unstalled edges capture.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 32'h00221821, 32'h0, 32'h00000020 + 32'(i), 32'h0,
               1'b1, 1'b0, 1'b1, 5'd3, 32'h00000020 + 32'(i), "stalled");
         drive(1'b1, 1'b0, 32'h00221821, 32'h0, 32'h00000030 + 32'(i), 32'h0,
               1'b1, 1'b0, 1'b1, 5'd3, 32'h00000030 + 32'(i), "unstalled");
      end
      idle();
      drain();

      // Counter wrap from all-ones.
      @(negedge clock);
      force dut.count_q = 32'hFFFFFFFF;
      @(negedge clock);
      release dut.count_q;
      exp_cnt = 32'hFFFFFFFF;
      drive(1'b1, 1'b0, 32'h00221821, 32'h0, 32'h00000042, 32'h0,
            1'b1, 1'b0, 1'b1, 5'd3, 32'h00000042, "count_wrap");
      drive(1'b1, 1'b0, 32'h00221821, 32'h0, 32'h00000055, 32'h0,
            1'b1, 1'b0, 1'b1, 5'd3, 32'h00000055, "after_wrap");
      idle();
      drain();

      // Asynchronous reset mid-cycle clears outputs without a clock edge.
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset.data", wb_data, 32'h0);
      check("async_reset.rd", 32'(wb_rd), 32'h0);
      check("async_reset.we", 32'(wb_we), 32'h0);
      check("async_reset.misaligned", 32'(misaligned), 32'h0);
      check("async_reset.count", retired_count, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/writeback.md
# writeback

Final (fifth) stage of the MIPS pipeline: takes the instruction retiring from `mem_stage` (instruction word, PC, ALU result/effective address, loaded memory word), picks the register-file destination, and builds the write-back value. Loaded words get byte/halfword extraction and sign/zero extension; JAL/JALR get a link value. Outputs are registered and drive `decode`'s `writeBackData`, `rdIn` and `regWriteEnable`, plus a retired-instruction counter and a misaligned-load flag.

## Interface
- `RESET_PC_LINK`, 8: offset added to `pc_in` to form the link value for JAL/JALR.
- `clock`  in  1  single pipeline clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  the inputs below carry a real instruction this cycle.
- `stall`  in  1  when high, inputs are not captured and a bubble is issued.
- `insn_in`  in  32 [0:31]  instruction word retiring from `mem_stage`.
- `pc_in`  in  32 [0:31]  PC of that instruction.
- `alu_result_in`  in  32 [0:31]  ALU result; effective address for loads.
- `mem_data_in`  in  32 [0:31]  word read by `mem_stage` at the word-aligned address.
- `wb_data`  out  32 [0:31]  value to write (to `decode.writeBackData`).
- `wb_rd`  out  5 [4:0]  destination register (to `decode.rdIn`).
- `wb_we`  out  1  register write strobe (to `decode.regWriteEnable`).
- `misaligned`  out  1  one-cycle pulse: the captured load was misaligned.
- `retired_count`  out  32 [0:31]  count of captured valid instructions.

## Operation
- Capture: at a rising edge with `valid_in`=1 and `stall`=0, latch all inputs and compute outputs. Otherwise the next cycle is a bubble: `wb_we`=0, `misaligned`=0, `wb_data`/`wb_rd` hold their previous values, and the counter holds.
- Decode, opcode = insn[0:5], rt = insn[11:15], rd = insn[16:20], funct = insn[26:31]:
  - opcode 0x00: destination rd, data `alu_result_in`. No write for funct 0x08 (JR), 0x11/0x13 (MTHI/MTLO), 0x18–0x1B (MULT/DIV family), or insn = 0 (NOP). For funct 0x09 (JALR), data = `pc_in`+`RESET_PC_LINK`.
  - opcode 0x03 (JAL): destination 31, data = `pc_in`+`RESET_PC_LINK`.
  - opcodes 0x08–0x0F (immediate ALU ops and LUI): destination rt, data `alu_result_in`.
  - Loads, destination rt: 0x20 LB, 0x24 LBU, 0x21 LH, 0x25 LHU, 0x23 LW.
  - Any other opcode (branches, J, stores, unknown): no write.
- Load extraction is big-endian, a = `alu_result_in`[30:31]:
  - byte a = `mem_data_in`[8a:8a+7];
  - halfword a = 0 → bits [0:15], a = 2 → bits [16:31];
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- Misaligned (LH/LHU with a odd, LW with a ≠ 0): `misaligned`=1, `wb_we`=0, and `wb_rd`/`wb_data` still update to the computed values.
- Writes to register 0 are suppressed: `wb_we`=0, and `wb_rd`/`wb_data` still update.
- `retired_count` increments by 1 on every capture, including non-writing and misaligned instructions. It wraps from 0xFFFFFFFF to 0.
- Link addition is modulo 2^32.

## Timing
- Latency is 1 cycle: an instruction captured at edge N has its outputs valid from edge N until edge N+1.
- `wb_we` is high for exactly one cycle per writing instruction, so back-to-back captures give back-to-back strobes.
- `stall` takes priority over `valid_in`.
- Reset (asynchronous assert, deassert sampled at the edge) forces: `wb_data`=0, `wb_rd`=0, `wb_we`=0, `misaligned`=0, `retired_count`=0.
- Reset during a capture discards that instruction. The first capture is possible at the first rising edge after `reset_n` rises.
- `decode` writes its register file on the edge following `wb_we`=1. `writeback` does no forwarding itself.

## Test plan
- ADDU $3,$1,$2 (insn 0x00221821), `alu_result_in`=0x0000_0007 → next cycle `wb_rd`=3, `wb_data`=7, `wb_we`=1, `retired_count`=1.
- LB at address 0x8002_0001, `mem_data_in`=0x1280_3456, rt=5 → `wb_data`=0xFFFF_FF80, `wb_we`=1. The same with LBU → 0x0000_0080.
- LH at address 0x8002_0002, `mem_data_in`=0x1234_ABCD → `wb_data`=0xFFFF_ABCD. LW at address 0x8002_0002 → `misaligned`=1 for one cycle, `wb_we`=0, counter still increments.
- JAL at `pc_in`=0x8002_0010 → `wb_rd`=31, `wb_data`=0x8002_0018. SW, BEQ, NOP and ADDI with rt=0 → `wb_we`=0.
- Alternate `stall` 1/0 with `valid_in`=1 → `wb_we` pulses only after unstalled edges, and the counter equals the number of unstalled edges.
- Preload `retired_count` to 0xFFFF_FFFF (force), capture one instruction → 0. Assert `reset_n`=0 mid-cycle → all outputs 0 immediately, without waiting for an edge.
